// File: rtl/halfband_up2_if.sv
// Sample-stream interface for the half-band interpolator: one input sample in,
// an odd/even output pair plus saturation flag out, every clock.
interface halfband_up2_if #(
    parameter int XIN_WIDTH  = 16,
    parameter int YOUT_WIDTH = 16
);
    logic signed [XIN_WIDTH-1:0]  xin;
    logic signed [YOUT_WIDTH-1:0] yout0;
    logic signed [YOUT_WIDTH-1:0] yout1;
    logic                         ovf;

    modport master (output xin, input yout0, yout1, ovf);
    modport slave  (input xin, output yout0, yout1, ovf);
endinterface

// File: rtl/halfband_up2.sv
// Half-band interpolate-by-2 FIR: symmetric polyphase branch (yout1) and
// center-tap delay branch (yout0), six register stages, round/saturate output.
module halfband_up2 #(
    parameter int XIN_WIDTH      = 16,
    parameter int COE_WIDTH      = 16,
    parameter int NUM_UNIQUE_COE = 3,
    parameter logic signed [COE_WIDTH-1:0] COE_NUMS [NUM_UNIQUE_COE] =
        '{16'sd1277, -16'sd4710, 16'sd20014},
    parameter int YOUT_WIDTH     = 16,
    parameter int SRA_BITS       = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    halfband_up2_if.slave        hb
);
    localparam int N         = NUM_UNIQUE_COE;
    localparam int TAPS      = 2 * N;
    localparam int NUM_PAIRS = (N + 1) / 2;
    localparam int PRE_W     = XIN_WIDTH + 1;
    localparam int PROD_W    = PRE_W + COE_WIDTH;
    localparam int ACC_W     = PROD_W + $clog2(N);
    localparam int CTR_DLY   = 4;

    typedef logic signed [XIN_WIDTH-1:0]  samp_t;
    typedef logic signed [PRE_W-1:0]      pre_t;
    typedef logic signed [PROD_W-1:0]     prod_t;
    typedef logic signed [ACC_W-1:0]      acc_t;
    typedef logic signed [ACC_W:0]        ext_t;
    typedef logic signed [YOUT_WIDTH-1:0] yout_t;

    typedef struct packed {
        logic  sat;
        yout_t y;
    } rs_t;

    localparam ext_t RND_HALF = ext_t'(1) <<< (SRA_BITS - 1);
    localparam ext_t Y_MAX    = ext_t'((64'sd1 <<< (YOUT_WIDTH - 1)) - 64'sd1);
    localparam ext_t Y_MIN    = -Y_MAX - ext_t'(1);

    // Round half-up, arithmetic shift, clamp to the output range.
    function automatic rs_t round_sat(input acc_t acc);
        ext_t shifted;
        rs_t  r;
        shifted = (ext_t'(acc) + RND_HALF) >>> SRA_BITS;
        if (shifted > Y_MAX) begin
            r.sat = 1'b1;
            r.y   = Y_MAX[YOUT_WIDTH-1:0];
        end else if (shifted < Y_MIN) begin
            r.sat = 1'b1;
            r.y   = Y_MIN[YOUT_WIDTH-1:0];
        end else begin
            r.sat = 1'b0;
            r.y   = shifted[YOUT_WIDTH-1:0];
        end
        return r;
    endfunction

    samp_t dl_q   [TAPS],      dl_d   [TAPS];
    pre_t  pre_q  [N],         pre_d  [N];
    prod_t prod_q [N],         prod_d [N];
    acc_t  sum1_q [NUM_PAIRS], sum1_d [NUM_PAIRS];
    acc_t  sum2_q,             sum2_d;
    samp_t ctr_q  [CTR_DLY],   ctr_d  [CTR_DLY];
    yout_t yout0_q, yout0_d;
    yout_t yout1_q, yout1_d;
    logic  ovf_q,   ovf_d;

    acc_t  prod_ext [2*NUM_PAIRS];
    rs_t   rs0, rs1;

    // NOTE: every intermediate written here gets a default first so no latch is inferred.
    always_comb begin
        dl_d[0] = hb.xin;
        for (int j = 1; j < TAPS; j++) dl_d[j] = dl_q[j-1];

        for (int k = 0; k < N; k++) begin
            pre_d[k]  = pre_t'(dl_q[k]) + pre_t'(dl_q[TAPS-1-k]);
            prod_d[k] = prod_t'(pre_q[k]) * prod_t'(COE_NUMS[k]);
        end

        // Zero-padded view so an odd coefficient count pairs up cleanly.
        for (int j = 0; j < 2*NUM_PAIRS; j++) prod_ext[j] = '0;
        for (int k = 0; k < N; k++) prod_ext[k] = acc_t'(prod_q[k]);
        for (int j = 0; j < NUM_PAIRS; j++) sum1_d[j] = prod_ext[2*j] + prod_ext[2*j+1];

        sum2_d = '0;
        for (int j = 0; j < NUM_PAIRS; j++) sum2_d = sum2_d + sum1_q[j];

        ctr_d[0] = dl_q[N];
        for (int j = 1; j < CTR_DLY; j++) ctr_d[j] = ctr_q[j-1];

        rs0     = round_sat(acc_t'(ctr_q[CTR_DLY-1]) <<< SRA_BITS);
        rs1     = round_sat(sum2_q);
        yout0_d = rs0.y;
        yout1_d = rs1.y;
        ovf_d   = rs0.sat | rs1.sat;
    end

    // NOTE: the delay line is cleared on reset too, so history never leaks across a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < TAPS; j++)      dl_q[j]   <= '0;
            for (int k = 0; k < N; k++)         pre_q[k]  <= '0;
            for (int k = 0; k < N; k++)         prod_q[k] <= '0;
            for (int j = 0; j < NUM_PAIRS; j++) sum1_q[j] <= '0;
            for (int j = 0; j < CTR_DLY; j++)   ctr_q[j]  <= '0;
            sum2_q  <= '0;
            yout0_q <= '0;
            yout1_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            dl_q    <= dl_d;
            pre_q   <= pre_d;
            prod_q  <= prod_d;
            sum1_q  <= sum1_d;
            ctr_q   <= ctr_d;
            sum2_q  <= sum2_d;
            yout0_q <= yout0_d;
            yout1_q <= yout1_d;
            ovf_q   <= ovf_d;
        end
    end

    assign hb.yout0 = yout0_q;
    assign hb.yout1 = yout1_q;
    assign hb.ovf   = ovf_q;
endmodule

// File: tb/tb_halfband_up2.sv
// Directed and bit-true random bench for halfband_up2 using immediate assertions.
module tb_halfband_up2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    halfband_up2_if #(.XIN_WIDTH(16), .YOUT_WIDTH(16)) hb ();

    halfband_up2 #(
        .XIN_WIDTH(16), .COE_WIDTH(16), .NUM_UNIQUE_COE(3),
        .YOUT_WIDTH(16), .SRA_BITS(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hb  (hb)
    );

    typedef struct {
        int y0;
        int y1;
        int ov;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   hist [6];
    exp_t expq [$];

    localparam int COE [3] = '{1277, -4710, 20014};
    int imp1 [11] = '{0, 0, 0, 0, 0, 639, -2355, 10007, 10007, -2355, 639};
    int imp0 [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 16384, 0, 0};

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void rs_model(input longint acc, output int y, output int s);
        longint r;
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767)       begin y = 32767;  s = 1; end
        else if (r < -32768) begin y = -32768; s = 1; end
        else                 begin y = int'(r); s = 0; end
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 6; j++) hist[j] = 0;
        expq.delete();
        repeat (5) expq.push_back('{0, 0, 0});
    endtask

    // One sample per clock; checks the pair that belongs to the sample from five edges earlier.
    task automatic drive(input logic signed [15:0] x);
        longint acc0, acc1;
        int y0, y1, s0, s1;
        exp_t e;
        for (int j = 5; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = int'(x);
        acc1 = 0;
        for (int k = 0; k < 3; k++)
            acc1 += longint'(COE[k]) * (longint'(hist[k]) + longint'(hist[5-k]));
        acc0 = longint'(hist[3]) * 32768;
        rs_model(acc0, y0, s0);
        rs_model(acc1, y1, s1);
        expq.push_back('{y0, y1, s0 | s1});
        hb.xin = x;
        @(posedge clk);
        #1;
        e = expq.pop_front();
        check("model_y0", hb.yout0, e.y0);
        check("model_y1", hb.yout1, e.y1);
        check("model_ovf", hb.ovf, e.ov);
    endtask

    task automatic hold_reset(input logic signed [15:0] x, input int n);
        rst = 1'b1;
        for (int j = 0; j < n; j++) begin
            hb.xin = x;
            @(posedge clk);
            #1;
            check("rst_y0", hb.yout0, 0);
            check("rst_y1", hb.yout1, 0);
            check("rst_ovf", hb.ovf, 0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        hb.xin = 16'sh7FFF;

        // Reset holds everything at zero even with a full-scale input.
        hold_reset(16'sh7FFF, 6);
        for (int j = 0; j < 8; j++) begin
            drive(16'sd0);
            check("post_rst_y1", hb.yout1, 0);
        end

        // Impulse response on yout1, center tap on yout0.
        for (int k = 0; k < 11; k++) begin
            drive(k == 0 ? 16'sd16384 : 16'sd0);
            check("imp_y1", hb.yout1, imp1[k]);
            check("imp_y0", hb.yout0, imp0[k]);
            check("imp_ovf", hb.ovf, 0);
        end

        // DC gain.
        repeat (12) drive(16'sd10000);
        check("dc_y1", hb.yout1, 10120);
        check("dc_y0", hb.yout0, 10000);
        check("dc_ovf", hb.ovf, 0);

        // Positive and negative full-scale saturation.
        repeat (12) drive(16'sh7FFF);
        check("satp_y1", hb.yout1, 32767);
        check("satp_y0", hb.yout0, 32767);
        check("satp_ovf", hb.ovf, 1);
        repeat (12) drive(16'sh8000);
        check("satn_y1", hb.yout1, -32768);
        check("satn_y0", hb.yout0, -32768);
        check("satn_ovf", hb.ovf, 1);

        // Step latency: yout1 moves after 6 edges, yout0 three clocks later.
        repeat (12) drive(16'sd0);
        for (int k = 0; k < 9; k++) begin
            drive(16'sd5000);
            check("lat_y1_nz", int'(hb.yout1 != 0), int'(k >= 5));
            check("lat_y0_nz", int'(hb.yout0 != 0), int'(k >= 8));
        end

        // Random full-scale stream with a reset pulse partway through.
        for (int n = 0; n < 4096; n++) begin
            if (n == 2048) hold_reset(16'($urandom), 2);
            drive(16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
